// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg
//   Shared definitions for the store buffer: data-memory addrmode encodings,
//   default sizing and the packed entry layout {addr, data, addrmode}.
//   The entry typedef uses the default widths. The RTL modules build the
//   same layout as a flat vector so that ADDRESS_WIDTH and DATA_WIDTH can be
//   overridden per instance.
package store_buffer_pkg;

    localparam int SB_ADDRESS_WIDTH = 32;
    localparam int SB_DATA_WIDTH    = 32;
    localparam int SB_DEPTH         = 4;
    localparam int AM_W             = 3;

    // Data-memory addrmode encodings (loads and stores share the code space).
    localparam logic [AM_W-1:0] AM_BYTE   = 3'b000;   // LB / SB
    localparam logic [AM_W-1:0] AM_HALF   = 3'b001;   // LH / SH
    localparam logic [AM_W-1:0] AM_WORD   = 3'b010;   // LW / SW
    localparam logic [AM_W-1:0] AM_BYTE_U = 3'b100;   // LBU
    localparam logic [AM_W-1:0] AM_HALF_U = 3'b101;   // LHU

    typedef struct packed {
        logic [SB_ADDRESS_WIDTH-1:0] addr;
        logic [SB_DATA_WIDTH-1:0]    data;
        logic [AM_W-1:0]             addrmode;
    } entry_t;

endpackage

// File: rtl/sb_fifo.sv
// sb_fifo
//   Entry storage for the store buffer: a DEPTH-deep FIFO of packed
//   {addr, data, addrmode} entries with per-entry valid bits, read/write
//   pointers and an occupancy count.
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   push, push_entry : write one entry at the tail (caller guarantees !full)
//   pop          : retire the head entry (caller guarantees !empty)
//   head_entry   : current head entry (always driven, zero after reset)
//   entry_word   : word address (addr[AW-1:2]) of every slot, for hazard compare
//   entry_valid  : per-slot valid bits
//   count, empty, full : occupancy
module sb_fifo
    import store_buffer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = SB_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = SB_DATA_WIDTH,
    parameter int DEPTH         = SB_DEPTH
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          push,
    input  logic [ADDRESS_WIDTH+DATA_WIDTH+AM_W-1:0]      push_entry,
    input  logic                                          pop,
    output logic [ADDRESS_WIDTH+DATA_WIDTH+AM_W-1:0]      head_entry,
    output logic [ADDRESS_WIDTH-3:0]                      entry_word [DEPTH],
    output logic [DEPTH-1:0]                              entry_valid,
    output logic [$clog2(DEPTH):0]                        count,
    output logic                                          empty,
    output logic                                          full
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDRESS_WIDTH + DATA_WIDTH + AM_W;
    // Bit position of the address field's LSB+2 inside a packed entry.
    localparam int WORD_LSB = DATA_WIDTH + AM_W + 2;

    logic [ENTRY_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]   valid_reg;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) wr_ptr_next = wr_ptr_reg + 1'b1;   // wraps modulo DEPTH
        if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
        if (push && !pop)      count_next = count_reg + 1'b1;
        else if (pop && !push) count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            for (int i = 0; i < DEPTH; i++) begin
                // Push and pop never target the same slot in one cycle:
                // that would need the buffer to be both empty and full.
                if (push && wr_ptr_reg == PTR_W'(i)) begin
                    mem_reg[i]   <= push_entry;
                    valid_reg[i] <= 1'b1;
                end else if (pop && rd_ptr_reg == PTR_W'(i)) begin
                    valid_reg[i] <= 1'b0;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign entry_word[gi] = mem_reg[gi][ENTRY_W-1:WORD_LSB];
        end
    endgenerate

    assign entry_valid = valid_reg;
    assign head_entry  = mem_reg[rd_ptr_reg];
    assign count       = count_reg;
    assign empty       = (count_reg == '0);
    assign full        = (count_reg == CNT_W'(DEPTH));

endmodule

// File: rtl/store_buffer.sv
// store_buffer
//   Decouples core stores from the single data-memory port. Stores are
//   queued in order and drained whenever the port is not taken by a load.
//   A load whose word address matches any buffered store is stalled until
//   that store has drained (the stalled load never blocks draining).
// Ports
//   clk, rst_n                          : clock, asynchronous active-low reset
//   st_valid/st_ready, st_addr, st_data, st_addrmode : store request
//   ld_req, ld_addr, ld_addrmode, ld_stall          : load request / hazard stall
//   mem_we, mem_addr, mem_wdata, mem_addrmode, mem_selectbytes : data memory
//   count                               : occupied entries
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int ADDRESS_WIDTH = SB_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = SB_DATA_WIDTH,
    parameter int DEPTH         = SB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [ADDRESS_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0]    st_data,
    input  logic [2:0]               st_addrmode,
    input  logic                     ld_req,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr,
    input  logic [2:0]               ld_addrmode,
    output logic                     ld_stall,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [2:0]               mem_addrmode,
    output logic [1:0]               mem_selectbytes,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ENTRY_W = ADDRESS_WIDTH + DATA_WIDTH + AM_W;

    logic                     push, pop;
    logic [ENTRY_W-1:0]       push_entry, head_entry;
    logic [ADDRESS_WIDTH-3:0] entry_word [DEPTH];
    logic [DEPTH-1:0]         entry_valid;
    logic [DEPTH-1:0]         match;
    logic                     empty, full;
    logic                     load_grant;

    logic [ADDRESS_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0]    head_data;
    logic [AM_W-1:0]          head_addrmode;

    assign st_ready   = !full;
    assign push       = st_valid && !full;
    assign push_entry = {st_addr, st_data, st_addrmode};

    sb_fifo #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .DEPTH        (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .entry_word (entry_word),
        .entry_valid(entry_valid),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    assign {head_addr, head_data, head_addrmode} = head_entry;

    // Word-granular hazard check against entries already in the buffer; a
    // store arriving in the same cycle is not yet visible here.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = entry_valid[gi] &&
                               (entry_word[gi] == ld_addr[ADDRESS_WIDTH-1:2]);
        end
    endgenerate

    assign ld_stall   = ld_req && (|match);
    assign load_grant = ld_req && !ld_stall;

    // Port arbitration: granted load, else drain head, else idle.
    always_comb begin
        pop          = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = ld_addr;
        mem_addrmode = ld_addrmode;
        if (!load_grant && !empty) begin
            pop          = 1'b1;
            mem_we       = 1'b1;
            mem_addr     = head_addr;
            mem_addrmode = head_addrmode;
        end
    end

    assign mem_wdata       = head_data;
    assign mem_selectbytes = mem_addr[1:0];

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, is the byte-address width.
REQ-002 Parameter DATA_WIDTH, default 32, is the store-data width.
REQ-003 Parameter DEPTH, default 4 (power of two, >=2), is the number of buffered stores.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 st_valid  in  1  core presents a store this cycle.
REQ-007 st_ready  out  1  buffer can accept a store.
REQ-008 st_addr  in  ADDRESS_WIDTH  store byte address.
REQ-009 st_data  in  DATA_WIDTH  store data from register file.
REQ-010 st_addrmode  in  3  store width/sign mode, same encoding as the data-memory addrmode.
REQ-011 ld_req  in  1  core requests the data-memory port for a load this cycle.
REQ-012 ld_addr  in  ADDRESS_WIDTH  load byte address.
REQ-013 ld_addrmode  in  3  load mode.
REQ-014 ld_stall  out  1  load must wait; the core holds ld_req/ld_addr.
REQ-015 mem_we  out  1  write_enable to data memory.
REQ-016 mem_addr  out  ADDRESS_WIDTH  address to data memory.
REQ-017 mem_wdata  out  DATA_WIDTH  write_data to data memory.
REQ-018 mem_addrmode  out  3  addrmode to data memory.
REQ-019 mem_selectbytes  out  2  selectbytes to data memory, always mem_addr[1:0].
REQ-020 count  out  $clog2(DEPTH)+1  occupied entries; empty/full are derived: empty = (count==0), full = (count==DEPTH).

Function
REQ-021 FIFO order: stores drain in exactly the order accepted.
REQ-022 st_ready = !full; a store is accepted on a clock edge where st_valid && st_ready.
REQ-023 A store accepted in cycle N is first eligible to drain in cycle N+1; there is no same-cycle bypass.
REQ-024 ld_stall = ld_req && any valid entry has entry.addr[ADDRESS_WIDTH-1:2] == ld_addr[ADDRESS_WIDTH-1:2]; only entries stored before this edge are compared.
REQ-025 Port arbitration (combinational, priority order):
- (a) ld_req && !ld_stall: load owns the port; mem_we=0, mem_addr=ld_addr, mem_addrmode=ld_addrmode, no pop.
- (b) otherwise, if !empty: head entry drains; mem_we=1, mem_addr/mem_wdata/mem_addrmode = head fields; pop on this edge.
- (c) otherwise idle: mem_we=0, mem_addr=ld_addr, mem_addrmode=ld_addrmode.
REQ-026 A stalled load never blocks draining, so a matching entry always retires within count cycles of the stall beginning (no deadlock).
REQ-027 Simultaneous push and pop: count unchanged; pointers both advance.
REQ-028 Push when full is impossible (st_ready=0); st_valid while full is ignored with no state change.
REQ-029 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-030 st_valid and ld_req in the same cycle are legal; both handshakes are evaluated independently.
REQ-031 mem_wdata is don't-care when mem_we=0, but is driven from the head entry (no X).

Reset
REQ-032 rst_n low asynchronously clears pointers, count and all entry valid bits; buffered stores are discarded.
REQ-033 During and after reset: st_ready=1, count=0, mem_we=0, ld_stall=0 (ld_req ignored while rst_n low).
REQ-034 Reset release takes effect on the first rising clk edge with rst_n high.

Structure
REQ-035 A shared package holds the addrmode encodings, DEPTH default, and the packed entry typedef {addr, data, addrmode}.
REQ-036 Entry storage plus pointers/count are one sub-module, sb_fifo; compare, arbitration and output muxing stay in store_buffer.

Verification
REQ-037 Reset mid-drain: 3 entries queued, rst_n low -> count=0, mem_we=0 immediately; after release, no write of the discarded data ever appears.
REQ-038 Fill/full: 4 back-to-back stores to 0x100..0x10C with ld_req=1 to non-matching 0x200 -> after the 4th, count=4 and st_ready=0; a 5th st_valid is ignored; releasing ld_req drains 0x100, 0x104, 0x108, 0x10C in order, one per cycle.
REQ-039 Load hazard: store SW 0xDEADBEEF to 0x40, next cycle ld_req to 0x42 -> ld_stall=1 and mem_we=1 with mem_addr=0x40; next cycle ld_stall=0, mem_addr=0x42, mem_we=0.
REQ-040 Byte store: SB 0x000000AB to 0x23 -> on drain, mem_selectbytes=2'b11, mem_addrmode=SB code, mem_wdata=0x000000AB.
REQ-041 Push+pop at count=2 -> count stays 2; run 10 stores to check pointer wrap keeps FIFO order.
REQ-042 Same-cycle st_valid to 0x80 and ld_req to 0x80 into an empty buffer -> ld_stall=0, load is granted the port, the store drains the following cycle.
